// File: rtl/alu_seq.sv
// alu_seq: registered valid/ready ALU. Define ALU_SEQ_MULDIV_EN to build the
// iterative MULU/DIVU/REMU datapath; without it opcodes 8-10 execute as ADD.
module alu_seq #(
   parameter int WIDTH = 32,
   parameter int SHW   = $clog2(WIDTH)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [3:0]       alu_sel,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] result,
   output logic             zero,
   output logic             negative,
   output logic             overflow,
   output logic             carry_out,
   output logic             div_by_zero
);

   localparam logic [3:0] OP_SUB  = 4'd1;
   localparam logic [3:0] OP_SRL  = 4'd2;
   localparam logic [3:0] OP_SLL  = 4'd3;
   localparam logic [3:0] OP_SRA  = 4'd4;
   localparam logic [3:0] OP_AND  = 4'd5;
   localparam logic [3:0] OP_OR   = 4'd6;
   localparam logic [3:0] OP_XOR  = 4'd7;
   localparam logic [3:0] OP_MULU = 4'd8;
   localparam logic [3:0] OP_DIVU = 4'd9;
   localparam logic [3:0] OP_REMU = 4'd10;
   localparam logic [3:0] OP_ROTL = 4'd11;
   localparam logic [3:0] OP_ROTR = 4'd12;

`ifdef ALU_SEQ_MULDIV_EN
   typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, DONE = 2'd2} state_t;
`else
   typedef enum logic [1:0] {IDLE = 2'd0, DONE = 2'd2} state_t;
`endif

   state_t             state_r, state_nxt_s;
   logic               in_ready_r, out_valid_r;
   logic [WIDTH-1:0]   result_r;
   logic               zero_r, negative_r, overflow_r, carry_r, dbz_r;
   logic               accept_s, is_iter_s;
   logic [SHW-1:0]     shamt_s;
   logic [WIDTH:0]     add_s, sub_s;
   logic [WIDTH-1:0]   sc_result_s;
   logic               sc_ovf_s, sc_carry_s, sc_dbz_s;
   logic               fin_s, fin_ovf_s;
   logic [WIDTH-1:0]   fin_result_s;

   assign accept_s = in_valid & in_ready_r;
   assign shamt_s  = b[SHW-1:0];
   assign add_s    = {1'b0, a} + {1'b0, b};
   assign sub_s    = {1'b0, a} - {1'b0, b};

`ifdef ALU_SEQ_MULDIV_EN
   localparam logic [SHW-1:0] CNT_LAST = SHW'(WIDTH - 1);

   logic [SHW-1:0]     cnt_r;
   logic [3:0]         op_r;
   logic [WIDTH-1:0]   opnd_r;
   logic [2*WIDTH-1:0] acc_r, acc_nxt_s;
   logic [WIDTH:0]     mul_sum_s, div_sh_s, div_diff_s;

   // b == 0 never iterates: MULU is trivially 0 and DIVU/REMU take the divide-by-zero path.
   assign is_iter_s = ((alu_sel == OP_MULU) || (alu_sel == OP_DIVU) || (alu_sel == OP_REMU))
                      && (b != {WIDTH{1'b0}});
   assign fin_s     = (state_r == BUSY) && (cnt_r == CNT_LAST);

   // One shift-add multiply or restoring-divide step on the accumulator.
   always_comb begin
      mul_sum_s  = {1'b0, acc_r[2*WIDTH-1:WIDTH]}
                   + (acc_r[0] ? {1'b0, opnd_r} : {(WIDTH+1){1'b0}});
      div_sh_s   = {acc_r[2*WIDTH-1:WIDTH], acc_r[WIDTH-1]};
      div_diff_s = div_sh_s - {1'b0, opnd_r};
      acc_nxt_s  = acc_r;
      if (op_r == OP_MULU) begin
         acc_nxt_s = {mul_sum_s, acc_r[WIDTH-1:1]};
      end else if (!div_diff_s[WIDTH]) begin
         acc_nxt_s = {div_diff_s[WIDTH-1:0], acc_r[WIDTH-2:0], 1'b1};
      end else begin
         acc_nxt_s = {div_sh_s[WIDTH-1:0], acc_r[WIDTH-2:0], 1'b0};
      end
   end

   // Final result comes from the accumulator after the last step so DONE follows it directly.
   always_comb begin
      fin_result_s = acc_nxt_s[WIDTH-1:0];
      fin_ovf_s    = 1'b0;
      if (op_r == OP_MULU) begin
         fin_ovf_s = |acc_nxt_s[2*WIDTH-1:WIDTH];
      end else if (op_r == OP_REMU) begin
         fin_result_s = acc_nxt_s[2*WIDTH-1:WIDTH];
      end else begin
         fin_result_s = acc_nxt_s[WIDTH-1:0];
      end
   end

   // Iteration counter, operand capture and accumulator.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cnt_r  <= {SHW{1'b0}};
         op_r   <= 4'd0;
         opnd_r <= {WIDTH{1'b0}};
         acc_r  <= {(2*WIDTH){1'b0}};
      end else if (accept_s) begin
         cnt_r  <= {SHW{1'b0}};
         op_r   <= alu_sel;
         opnd_r <= (alu_sel == OP_MULU) ? a : b;
         acc_r  <= (alu_sel == OP_MULU) ? {{WIDTH{1'b0}}, b} : {{WIDTH{1'b0}}, a};
      end else if (state_r == BUSY) begin
         cnt_r  <= cnt_r + {{(SHW-1){1'b0}}, 1'b1};
         acc_r  <= acc_nxt_s;
      end
   end
`else
   assign is_iter_s    = 1'b0;
   assign fin_s        = 1'b0;
   assign fin_ovf_s    = 1'b0;
   assign fin_result_s = {WIDTH{1'b0}};
`endif

   // Single-cycle result and flags computed from the live operands.
   always_comb begin
      sc_result_s = add_s[WIDTH-1:0];
      sc_carry_s  = add_s[WIDTH];
      sc_ovf_s    = (a[WIDTH-1] == b[WIDTH-1]) && (add_s[WIDTH-1] != a[WIDTH-1]);
      sc_dbz_s    = 1'b0;
      case (alu_sel)
         OP_SUB: begin
            sc_result_s = sub_s[WIDTH-1:0];
            sc_carry_s  = ~sub_s[WIDTH];
            sc_ovf_s    = (a[WIDTH-1] != b[WIDTH-1]) && (sub_s[WIDTH-1] != a[WIDTH-1]);
         end
         OP_SRL:  begin sc_result_s = a >> 1'b1; sc_carry_s = 1'b0; sc_ovf_s = 1'b0; end
         OP_SLL:  begin sc_result_s = a << 1'b1; sc_carry_s = 1'b0; sc_ovf_s = 1'b0; end
         OP_SRA:  begin
            sc_result_s = $unsigned($signed(a) >>> shamt_s);
            sc_carry_s  = 1'b0;
            sc_ovf_s    = 1'b0;
         end
         OP_AND:  begin sc_result_s = a & b; sc_carry_s = 1'b0; sc_ovf_s = 1'b0; end
         OP_OR:   begin sc_result_s = a | b; sc_carry_s = 1'b0; sc_ovf_s = 1'b0; end
         OP_XOR:  begin sc_result_s = a ^ b; sc_carry_s = 1'b0; sc_ovf_s = 1'b0; end
         OP_ROTL: begin
            sc_result_s = (a << shamt_s) | (a >> (WIDTH - int'(shamt_s)));
            sc_carry_s  = 1'b0;
            sc_ovf_s    = 1'b0;
         end
         OP_ROTR: begin
            sc_result_s = (a >> shamt_s) | (a << (WIDTH - int'(shamt_s)));
            sc_carry_s  = 1'b0;
            sc_ovf_s    = 1'b0;
         end
`ifdef ALU_SEQ_MULDIV_EN
         OP_MULU: begin sc_result_s = {WIDTH{1'b0}}; sc_carry_s = 1'b0; sc_ovf_s = 1'b0; end
         OP_DIVU: begin
            sc_result_s = {WIDTH{1'b1}};
            sc_carry_s  = 1'b0;
            sc_ovf_s    = 1'b0;
            sc_dbz_s    = 1'b1;
         end
         OP_REMU: begin
            sc_result_s = a;
            sc_carry_s  = 1'b0;
            sc_ovf_s    = 1'b0;
            sc_dbz_s    = 1'b1;
         end
`endif
         default: begin
            sc_result_s = add_s[WIDTH-1:0];
         end
      endcase
   end

   // Next-state logic.
   always_comb begin
      state_nxt_s = state_r;
      case (state_r)
         IDLE: begin
            if (accept_s) begin
`ifdef ALU_SEQ_MULDIV_EN
               state_nxt_s = is_iter_s ? BUSY : DONE;
`else
               state_nxt_s = DONE;
`endif
            end else begin
               state_nxt_s = IDLE;
            end
         end
`ifdef ALU_SEQ_MULDIV_EN
         BUSY: begin
            if (fin_s) state_nxt_s = DONE;
            else       state_nxt_s = BUSY;
         end
`endif
         DONE: begin
            if (out_ready) state_nxt_s = IDLE;
            else           state_nxt_s = DONE;
         end
         default: state_nxt_s = IDLE;
      endcase
   end

   // State register.
   always_ff @(posedge clk) begin
      if (!rst_n) state_r <= IDLE;
      else        state_r <= state_nxt_s;
   end

   // Registered handshake, result and flags.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         in_ready_r  <= 1'b0;
         out_valid_r <= 1'b0;
         result_r    <= {WIDTH{1'b0}};
         zero_r      <= 1'b0;
         negative_r  <= 1'b0;
         overflow_r  <= 1'b0;
         carry_r     <= 1'b0;
         dbz_r       <= 1'b0;
      end else begin
         in_ready_r  <= (state_nxt_s == IDLE);
         out_valid_r <= (state_nxt_s == DONE);
         if (accept_s && !is_iter_s) begin
            result_r   <= sc_result_s;
            zero_r     <= (sc_result_s == {WIDTH{1'b0}});
            negative_r <= sc_result_s[WIDTH-1];
            overflow_r <= sc_ovf_s;
            carry_r    <= sc_carry_s;
            dbz_r      <= sc_dbz_s;
         end else if (fin_s) begin
            result_r   <= fin_result_s;
            zero_r     <= (fin_result_s == {WIDTH{1'b0}});
            negative_r <= fin_result_s[WIDTH-1];
            overflow_r <= fin_ovf_s;
            carry_r    <= 1'b0;
            dbz_r      <= 1'b0;
         end
      end
   end

   assign in_ready    = in_ready_r;
   assign out_valid   = out_valid_r;
   assign result      = result_r;
   assign zero        = zero_r;
   assign negative    = negative_r;
   assign overflow    = overflow_r;
   assign carry_out   = carry_r;
   assign div_by_zero = dbz_r;

endmodule

// File: tb/tb_alu_seq.sv
// Directed self-checking bench for alu_seq; expectations follow ALU_SEQ_MULDIV_EN.
module tb_alu_seq;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [31:0] a = 32'd0;
   logic [31:0] b = 32'd0;
   logic [3:0]  alu_sel = 4'd0;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [31:0] result;
   logic        zero, negative, overflow, carry_out, div_by_zero;

`ifdef ALU_SEQ_MULDIV_EN
   localparam bit MD = 1'b1;
`else
   localparam bit MD = 1'b0;
`endif

   typedef struct packed {
      logic [3:0]  op;
      logic [31:0] va;
      logic [31:0] vb;
      logic [31:0] res;
      logic [4:0]  flg;
      logic [7:0]  lat;
   } vec_t;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   alu_seq dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .a(a), .b(b), .alu_sel(alu_sel), .out_valid(out_valid), .out_ready(out_ready),
      .result(result), .zero(zero), .negative(negative), .overflow(overflow),
      .carry_out(carry_out), .div_by_zero(div_by_zero)
   );

   task automatic accept_op(input logic [3:0] op, input logic [31:0] ia, input logic [31:0] ib);
      int n;
      n = 0;
      while (in_ready !== 1'b1 && n < 50) begin
         @(negedge clk);
         n++;
      end
      alu_sel = op; a = ia; b = ib; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
   endtask

   task automatic wait_valid(output int lat, output bit saw_ready);
      lat = 0;
      saw_ready = 1'b0;
      do begin
         @(negedge clk);
         lat++;
         if (in_ready === 1'b1) saw_ready = 1'b1;
      end while (out_valid !== 1'b1 && lat < 100);
      if (out_valid !== 1'b1) lat = 0;
   endtask

   task automatic consume();
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      n_checks++;
      if ({in_ready, out_valid, result, zero, negative, overflow, carry_out, div_by_zero} !== 39'd0) begin
         n_fail++;
         $display("FAIL reset_state: got rdy=%b vld=%b res=%h flags=%b required all zero", in_ready,
                  out_valid, result, {zero, negative, overflow, carry_out, div_by_zero});
      end
      rst_n = 1'b1;
      @(negedge clk);
      n_checks++;
      if (in_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL reset_release_ready: got %b required 1", in_ready);
      end
   endtask

   task automatic test_add();
      int lat; bit sr;
      accept_op(4'd0, 32'h7FFF_FFFF, 32'h0000_0001);
      wait_valid(lat, sr);
      n_checks++;
      if (lat != 1) begin n_fail++; $display("FAIL add_latency: got %0d required 1", lat); end
      n_checks++;
      if ({result, zero, negative, overflow, carry_out, div_by_zero} !== {32'h8000_0000, 5'b01100}) begin
         n_fail++;
         $display("FAIL add_overflow: got %h/%b required 80000000/01100", result,
                  {zero, negative, overflow, carry_out, div_by_zero});
      end
      consume();
      n_checks++;
      if ({out_valid, in_ready} !== 2'b01) begin
         n_fail++;
         $display("FAIL add_consume: got vld,rdy=%b required 01", {out_valid, in_ready});
      end
   endtask

   task automatic test_sub();
      int lat; bit sr;
      vec_t v[3];
      v[0] = '{4'd1, 32'd5, 32'd5, 32'h0000_0000, 5'b10010, 8'd1};
      v[1] = '{4'd1, 32'd3, 32'd5, 32'hFFFF_FFFE, 5'b01000, 8'd1};
      v[2] = '{4'd1, 32'h8000_0000, 32'd1, 32'h7FFF_FFFF, 5'b00110, 8'd1};
      for (int i = 0; i < 3; i++) begin
         accept_op(v[i].op, v[i].va, v[i].vb);
         wait_valid(lat, sr);
         n_checks++;
         if (lat != int'(v[i].lat) || {result, zero, negative, overflow, carry_out, div_by_zero} !== {v[i].res, v[i].flg}) begin
            n_fail++;
            $display("FAIL sub_%0d: got lat=%0d %h/%b required lat=%0d %h/%b", i, lat, result,
                     {zero, negative, overflow, carry_out, div_by_zero}, v[i].lat, v[i].res, v[i].flg);
         end
         consume();
      end
   endtask

   task automatic test_mul_stall();
      int lat; bit sr;
      logic [31:0] er;
      logic [4:0]  ef;
      er = MD ? 32'h0000_0000 : 32'h0002_0000;
      ef = MD ? 5'b10100 : 5'b00000;
      accept_op(4'd8, 32'h0001_0000, 32'h0001_0000);
      wait_valid(lat, sr);
      n_checks++;
      if (lat != (MD ? 33 : 1)) begin
         n_fail++;
         $display("FAIL mul_latency: got %0d required %0d", lat, MD ? 33 : 1);
      end
      n_checks++;
      if (sr) begin n_fail++; $display("FAIL mul_in_ready_busy: got 1 required 0"); end
      for (int c = 0; c < 6; c++) begin
         n_checks++;
         if ({out_valid, in_ready, result, zero, negative, overflow, carry_out, div_by_zero} !== {2'b10, er, ef}) begin
            n_fail++;
            $display("FAIL mul_stall_%0d: got vld=%b rdy=%b %h/%b required 1 0 %h/%b", c, out_valid, in_ready,
                     result, {zero, negative, overflow, carry_out, div_by_zero}, er, ef);
         end
         if (c < 5) @(negedge clk);
      end
      consume();
   endtask

   task automatic test_div();
      int lat; bit sr;
      vec_t v[8];
      v[0] = '{4'd9,  32'd100, 32'd7, MD ? 32'd14 : 32'd107, 5'b00000, MD ? 8'd33 : 8'd1};
      v[1] = '{4'd10, 32'd100, 32'd7, MD ? 32'd2  : 32'd107, 5'b00000, MD ? 8'd33 : 8'd1};
      v[2] = '{4'd9,  32'd9, 32'd0, MD ? 32'hFFFF_FFFF : 32'd9, MD ? 5'b01001 : 5'b00000, 8'd1};
      v[3] = '{4'd10, 32'd9, 32'd0, 32'd9, MD ? 5'b00001 : 5'b00000, 8'd1};
      v[4] = '{4'd9,  32'hFFFF_FFFF, 32'h10, MD ? 32'h0FFF_FFFF : 32'h0000_000F,
               MD ? 5'b00000 : 5'b00010, MD ? 8'd33 : 8'd1};
      v[5] = '{4'd10, 32'hFFFF_FFFF, 32'h10, 32'h0000_000F, MD ? 5'b00000 : 5'b00010, MD ? 8'd33 : 8'd1};
      v[6] = '{4'd8,  32'h0000_FFFF, 32'h0000_FFFF, MD ? 32'hFFFE_0001 : 32'h0001_FFFE,
               MD ? 5'b01000 : 5'b00000, MD ? 8'd33 : 8'd1};
      v[7] = '{4'd8,  32'h1234_5678, 32'h10, MD ? 32'h2345_6780 : 32'h1234_5688,
               MD ? 5'b00100 : 5'b00000, MD ? 8'd33 : 8'd1};
      for (int i = 0; i < 8; i++) begin
         accept_op(v[i].op, v[i].va, v[i].vb);
         wait_valid(lat, sr);
         n_checks++;
         if (lat != int'(v[i].lat) || {result, zero, negative, overflow, carry_out, div_by_zero} !== {v[i].res, v[i].flg}) begin
            n_fail++;
            $display("FAIL muldiv_%0d: got lat=%0d %h/%b required lat=%0d %h/%b", i, lat, result,
                     {zero, negative, overflow, carry_out, div_by_zero}, v[i].lat, v[i].res, v[i].flg);
         end
         consume();
      end
   endtask

   task automatic test_shift_rot_logic();
      int lat; bit sr;
      vec_t v[13];
      v[0]  = '{4'd4,  32'h8000_0000, 32'd4,  32'hF800_0000, 5'b01000, 8'd1};
      v[1]  = '{4'd11, 32'h8000_0001, 32'd33, 32'h0000_0003, 5'b00000, 8'd1};
      v[2]  = '{4'd12, 32'h0000_0001, 32'd1,  32'h8000_0000, 5'b01000, 8'd1};
      v[3]  = '{4'd14, 32'd2, 32'd3, 32'd5, 5'b00000, 8'd1};
      v[4]  = '{4'd2,  32'h8000_0001, 32'd0,  32'h4000_0000, 5'b00000, 8'd1};
      v[5]  = '{4'd3,  32'h8000_0001, 32'd0,  32'h0000_0002, 5'b00000, 8'd1};
      v[6]  = '{4'd5,  32'hF0F0_F0F0, 32'hFF00_FF00, 32'hF000_F000, 5'b01000, 8'd1};
      v[7]  = '{4'd6,  32'hF0F0_F0F0, 32'hFF00_FF00, 32'hFFF0_FFF0, 5'b01000, 8'd1};
      v[8]  = '{4'd7,  32'hF0F0_F0F0, 32'hFF00_FF00, 32'h0FF0_0FF0, 5'b00000, 8'd1};
      v[9]  = '{4'd5,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'b01000, 8'd1};
      v[10] = '{4'd15, 32'hFFFF_FFFF, 32'd1,  32'h0000_0000, 5'b10010, 8'd1};
      v[11] = '{4'd4,  32'h7FFF_FFFF, 32'd31, 32'h0000_0000, 5'b10000, 8'd1};
      v[12] = '{4'd13, 32'h8000_0000, 32'h8000_0000, 32'h0000_0000, 5'b10110, 8'd1};
      for (int i = 0; i < 13; i++) begin
         accept_op(v[i].op, v[i].va, v[i].vb);
         wait_valid(lat, sr);
         n_checks++;
         if (lat != int'(v[i].lat) || {result, zero, negative, overflow, carry_out, div_by_zero} !== {v[i].res, v[i].flg}) begin
            n_fail++;
            $display("FAIL single_%0d op=%0d: got lat=%0d %h/%b required lat=%0d %h/%b", i, v[i].op, lat,
                     result, {zero, negative, overflow, carry_out, div_by_zero}, v[i].lat, v[i].res, v[i].flg);
         end
         consume();
      end
   endtask

   task automatic test_reset_midop();
      bit stale;
      accept_op(4'd8, 32'h0001_0000, 32'h0001_0000);
      repeat (11) @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      n_checks++;
      if ({out_valid, in_ready, result} !== 34'd0) begin
         n_fail++;
         $display("FAIL midop_reset: got vld=%b rdy=%b res=%h required 0 0 00000000", out_valid, in_ready, result);
      end
      rst_n = 1'b1;
      @(negedge clk);
      n_checks++;
      if ({out_valid, in_ready} !== 2'b01) begin
         n_fail++;
         $display("FAIL midop_release: got vld,rdy=%b required 01", {out_valid, in_ready});
      end
      stale = 1'b0;
      repeat (40) begin
         @(negedge clk);
         if (out_valid !== 1'b0) stale = 1'b1;
      end
      n_checks++;
      if (stale) begin n_fail++; $display("FAIL midop_stale_output: got out_valid=1 required 0"); end
   endtask

   initial begin
      test_reset();
      test_add();
      test_sub();
      test_mul_stall();
      test_div();
      test_shift_rot_logic();
      test_reset_midop();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
